// File: rtl/nf_key_debounce_pkg.sv
// ---------------------------------------------------------------------------
// nf_key_pkg
// Shared types and constants for the push-button conditioning block.
//   key_st_t          : per-key debounce FSM state encoding
//   NF_KEY_DEB_50MHZ  : default stability window, 10 ms at a 50 MHz clock
// ---------------------------------------------------------------------------
package nf_key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_st_t;

  localparam int NF_KEY_DEB_50MHZ = 500_000;

endpackage

// File: rtl/nf_key_debounce_ch.sv
// ---------------------------------------------------------------------------
// nf_key_debounce_ch
// One key channel: 2-flop synchronizer, debounce FSM with stability counter,
// registered level / press pulse / release pulse / toggle outputs.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   i_pin      in   raw (asynchronous) key pin
//   o_state    out  debounced level, 1 = pressed
//   o_press    out  1-cycle pulse on accepted press
//   o_release  out  1-cycle pulse on accepted release
//   o_toggle   out  flips on every accepted press
// Parameters:
//   DEB_CYCLES  stability window in clock cycles (>= 2)
//   PIN_IDLE    pin level when the key is released
// ---------------------------------------------------------------------------
module nf_key_debounce_ch
  import nf_key_pkg::*;
#(
  parameter int DEB_CYCLES = NF_KEY_DEB_50MHZ,
  parameter bit PIN_IDLE   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_state,
  output logic o_press,
  output logic o_release,
  output logic o_toggle
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_pressed;

  key_st_t          r_st;
  key_st_t          w_st_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic             r_state;
  logic             r_press;
  logic             r_release;
  logic             r_toggle;
  logic             w_state_next;
  logic             w_press_next;
  logic             w_release_next;
  logic             w_toggle_next;

  // Sync flops come out of reset at the idle pin level so that leaving
  // reset can never look like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= PIN_IDLE;
      r_sync2 <= PIN_IDLE;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Polarity normalised after the synchronizer: 1 = pressed.
  assign w_pressed = r_sync2 ^ PIN_IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st      <= RELEASED;
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_st      <= w_st_next;
      r_cnt     <= w_cnt_next;
      r_state   <= w_state_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_toggle  <= w_toggle_next;
    end
  end

  // The counter is cleared on every state change and the transition fires
  // at CNT_LAST, so it can never run past the compare point.
  always_comb begin
    w_st_next      = r_st;
    w_cnt_next     = r_cnt;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_toggle_next  = r_toggle;
    case (r_st)
      RELEASED: begin
        if (w_pressed) begin
          w_st_next  = PRESS_WAIT;
          w_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_pressed) begin
          w_st_next  = RELEASED;
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_st_next     = PRESSED;
          w_cnt_next    = '0;
          w_press_next  = 1'b1;
          w_toggle_next = ~r_toggle;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!w_pressed) begin
          w_st_next  = RELEASE_WAIT;
          w_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_pressed) begin
          w_st_next  = PRESSED;
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_st_next      = RELEASED;
          w_cnt_next     = '0;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_st_next  = RELEASED;
        w_cnt_next = '0;
      end
    endcase
    // Level stays asserted while a release is still being qualified.
    w_state_next = (w_st_next == PRESSED) || (w_st_next == RELEASE_WAIT);
  end

  assign o_state   = r_state;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_toggle  = r_toggle;

endmodule

// File: rtl/nf_key_debounce.sv
// ---------------------------------------------------------------------------
// nf_key_debounce
// Conditions raw board push-buttons before they reach the GPIO input port.
// One independent debounce channel per key; this level only selects the
// pin polarity and packs the per-key outputs into vectors.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   key_raw      in   [KEY_NUM] raw asynchronous key pins
//   key_state    out  [KEY_NUM] debounced level, 1 = pressed
//   key_press    out  [KEY_NUM] 1-cycle pulse on accepted press
//   key_release  out  [KEY_NUM] 1-cycle pulse on accepted release
//   key_toggle   out  [KEY_NUM] flips on every accepted press
// Parameters:
//   KEY_NUM     number of key channels
//   DEB_CYCLES  stability window in cycles (>= 2)
//   ACTIVE_LOW  1: pin low = pressed, 0: pin high = pressed
// ---------------------------------------------------------------------------
module nf_key_debounce
  import nf_key_pkg::*;
#(
  parameter int KEY_NUM    = 4,
  parameter int DEB_CYCLES = NF_KEY_DEB_50MHZ,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_NUM-1:0] key_raw,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_toggle
);

  // A released active-low key idles high on the pin.
  localparam bit PIN_IDLE = ACTIVE_LOW;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_NUM; gi++) begin : g_key
      nf_key_debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .PIN_IDLE   (PIN_IDLE)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .i_pin     (key_raw[gi]),
        .o_state   (key_state[gi]),
        .o_press   (key_press[gi]),
        .o_release (key_release[gi]),
        .o_toggle  (key_toggle[gi])
      );
    end
  endgenerate

endmodule
